execute_stage: RTL and testbench

- Execute stage directly downstream of the Decode/Execute pipeline register.
- Consumes aluOp/srcA/srcB and produces a registered 16-bit result plus NZCV flags for the Execute/Memory register.
- Single-cycle ops: 1-cycle latency.
- MUL/DIV/MOD run iteratively. During those ops the stage stalls upstream through a valid/ready handshake.

---
 rtl/execute_stage.sv | 274 +++++++++++++++++++++++++++
 tb/tb_execute_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage: registered single-cycle ALU plus iterative MUL/DIV/MOD.
// Define EXEC_MULDIV_EN to build the iterative multiply/divide datapath.
module execute_stage #(
    parameter int WIDTH = 16,
    parameter int ITER  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             valid_in,
    input  logic [3:0]       aluOp_in,
    input  logic [WIDTH-1:0] srcA_in,
    input  logic [WIDTH-1:0] srcB_in,
    output logic             ready_out,
    output logic             valid_out,
    output logic             wb_en_out,
    output logic [WIDTH-1:0] result_out,
    output logic [3:0]       flags_out
);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SRL  = 4'h7;
    localparam logic [3:0] OP_SRA  = 4'h8;
    localparam logic [3:0] OP_CMP  = 4'h9;
    localparam logic [3:0] OP_MOV  = 4'hA;
    localparam logic [3:0] OP_MUL  = 4'hB;
    localparam logic [3:0] OP_DIV  = 4'hC;
    localparam logic [3:0] OP_PASS = 4'hE;
    localparam logic [3:0] OP_NOP  = 4'hF;

    if (ITER != WIDTH) begin : g_iter_chk
        $error("ITER must equal WIDTH");
    end

    logic [3:0]       sh;
    logic [WIDTH:0]   sc_ext;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c;
    logic             sc_v;
    logic             sc_wb;
    logic             sc_valid;
    logic [3:0]       sc_flags;

    assign sh = srcB_in[3:0];

    // Shifts run one bit wider so the last bit shifted out lands in sc_ext.
    always_comb begin
        sc_ext   = '0;
        sc_res   = '0;
        sc_c     = 1'b0;
        sc_v     = 1'b0;
        sc_wb    = 1'b1;
        sc_valid = 1'b1;
        unique case (aluOp_in)
            OP_ADD: begin
                sc_ext = {1'b0, srcA_in} + {1'b0, srcB_in};
                sc_res = sc_ext[WIDTH-1:0];
                sc_c   = sc_ext[WIDTH];
                sc_v   = (srcA_in[WIDTH-1] == srcB_in[WIDTH-1])
                      && (sc_res[WIDTH-1] != srcA_in[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                sc_ext = {1'b0, srcA_in} - {1'b0, srcB_in};
                sc_res = sc_ext[WIDTH-1:0];
                sc_c   = ~sc_ext[WIDTH];
                sc_v   = (srcA_in[WIDTH-1] != srcB_in[WIDTH-1])
                      && (sc_res[WIDTH-1] != srcA_in[WIDTH-1]);
                sc_wb  = (aluOp_in != OP_CMP);
            end
            OP_AND:  sc_res = srcA_in & srcB_in;
            OP_OR:   sc_res = srcA_in | srcB_in;
            OP_XOR:  sc_res = srcA_in ^ srcB_in;
            OP_NOT:  sc_res = ~srcA_in;
            OP_SLL: begin
                sc_ext = {1'b0, srcA_in} << sh;
                sc_res = sc_ext[WIDTH-1:0];
                sc_c   = sc_ext[WIDTH];
            end
            OP_SRL: begin
                sc_ext = {srcA_in, 1'b0} >> sh;
                sc_res = sc_ext[WIDTH:1];
                sc_c   = sc_ext[0];
            end
            OP_SRA: begin
                sc_ext = $signed({srcA_in, 1'b0}) >>> sh;
                sc_res = sc_ext[WIDTH:1];
                sc_c   = sc_ext[0];
            end
            OP_MOV:  sc_res = srcB_in;
            OP_PASS: sc_res = srcA_in;
            OP_NOP:  sc_valid = 1'b0;
            default: begin
                sc_v  = 1'b1;
                sc_wb = 1'b0;
            end
        endcase
    end

    assign sc_flags = {sc_res[WIDTH-1], sc_res == '0, sc_c, sc_v};

    logic             valid_q, valid_d;
    logic             wb_q, wb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;

`ifdef EXEC_MULDIV_EN
    localparam int CW = $clog2(ITER);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mc_q, mc_d;
    logic [WIDTH-1:0]   mp_q, mp_d;
    logic               ready_q, ready_d;

    logic [2*WIDTH-1:0] mul_sum;
    logic               mul_hi_nz;
    logic [WIDTH:0]     div_r;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] div_acc;
    logic [WIDTH-1:0]   div_res;
    logic               is_multi;

    assign is_multi = (aluOp_in == OP_MUL) || (aluOp_in == OP_DIV)
                   || (aluOp_in == 4'hD);

    // acc_q holds the product for MUL, {remainder, dividend/quotient} for DIV/MOD.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        mc_d     = mc_q;
        mp_d     = mp_q;
        ready_d  = ready_q;
        valid_d  = 1'b0;
        wb_d     = wb_q;
        result_d = result_q;
        flags_d  = flags_q;

        mul_sum   = acc_q + (mp_q[0] ? mc_q : '0);
        mul_hi_nz = (mul_sum[2*WIDTH-1:WIDTH] != '0);
        div_r     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = {1'b0, div_r} - {2'b00, mp_q};
        div_ok    = (div_diff[WIDTH+1:WIDTH] == 2'b00);
        div_acc   = {div_ok ? div_diff[WIDTH-1:0] : div_r[WIDTH-1:0],
                     acc_q[WIDTH-2:0], div_ok};
        div_res   = (op_q == OP_DIV) ? div_acc[WIDTH-1:0]
                                     : div_acc[2*WIDTH-1:WIDTH];

        unique case (state_q)
            S_IDLE: begin
                if (valid_in && !flush) begin
                    if (is_multi) begin
                        state_d = S_BUSY;
                        ready_d = 1'b0;
                        cnt_d   = '0;
                        op_d    = aluOp_in;
                        mp_d    = srcB_in;
                        mc_d    = {{WIDTH{1'b0}}, srcA_in};
                        acc_d   = (aluOp_in == OP_MUL) ? '0
                                : {{WIDTH{1'b0}}, srcA_in};
                    end else if (sc_valid) begin
                        valid_d  = 1'b1;
                        wb_d     = sc_wb;
                        result_d = sc_res;
                        flags_d  = sc_flags;
                    end
                end
            end
            S_BUSY: begin
                if (flush) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (op_q == OP_MUL) begin
                        acc_d = mul_sum;
                        mc_d  = mc_q << 1;
                        mp_d  = mp_q >> 1;
                    end else begin
                        acc_d = div_acc;
                    end
                    if (cnt_q == CW'(ITER - 1)) begin
                        state_d = S_IDLE;
                        ready_d = 1'b1;
                        cnt_d   = '0;
                        valid_d = 1'b1;
                        wb_d    = 1'b1;
                        if (op_q == OP_MUL) begin
                            result_d = mul_sum[WIDTH-1:0];
                            flags_d  = {mul_sum[WIDTH-1],
                                        mul_sum[WIDTH-1:0] == '0,
                                        mul_hi_nz, mul_hi_nz};
                        end else begin
                            result_d = div_res;
                            flags_d  = {div_res[WIDTH-1], div_res == '0,
                                        1'b0, mp_q == '0};
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            mc_q    <= '0;
            mp_q    <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            mp_q    <= mp_d;
            ready_q <= ready_d;
        end
    end

    assign ready_out = ready_q;
`else
    always_comb begin
        valid_d  = 1'b0;
        wb_d     = wb_q;
        result_d = result_q;
        flags_d  = flags_q;
        if (valid_in && !flush && sc_valid) begin
            valid_d  = 1'b1;
            wb_d     = sc_wb;
            result_d = sc_res;
            flags_d  = sc_flags;
        end
    end

    assign ready_out = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            wb_q     <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            wb_q     <= wb_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign valid_out  = valid_q;
    assign wb_en_out  = wb_q;
    assign result_out = result_q;
    assign flags_out  = flags_q;

endmodule

// File: tb/tb_execute_stage.sv
// Testbench for execute_stage: directed steps plus random ops vs a reference model.
`timescale 1ns/1ps
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        valid_in;
    logic [3:0]  aluOp_in;
    logic [15:0] srcA_in;
    logic [15:0] srcB_in;
    logic        ready_out;
    logic        valid_out;
    logic        wb_en_out;
    logic [15:0] result_out;
    logic [3:0]  flags_out;

    int total  = 0;
    int passed = 0;

    logic [15:0] last_res;

`ifdef EXEC_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    always #5 clk = ~clk;

    execute_stage #(.WIDTH(16), .ITER(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .valid_in  (valid_in),
        .aluOp_in  (aluOp_in),
        .srcA_in   (srcA_in),
        .srcB_in   (srcB_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .wb_en_out (wb_en_out),
        .result_out(result_out),
        .flags_out (flags_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic bit in_range(input int s);
        return (s <= 32767) && (s >= -32768);
    endfunction

    // Returns {wb, N, Z, C, V, result} from plain arithmetic on the operands.
    function automatic logic [20:0] model(input logic [3:0] op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
        logic [15:0] r;
        logic [31:0] p;
        logic        c, v, wb;
        int          sa, sb, s, sh;
        sa = $signed(a);
        sb = $signed(b);
        sh = int'(b[3:0]);
        r = '0; c = 1'b0; v = 1'b0; wb = 1'b1;
        case (op)
            4'h0: begin
                s = int'(a) + int'(b);
                r = 16'(s);
                c = (s > 65535);
                v = !in_range(sa + sb);
            end
            4'h1, 4'h9: begin
                r = a - b;
                c = (a >= b);
                v = !in_range(sa - sb);
                wb = (op != 4'h9);
            end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h5: r = ~a;
            4'h6: begin
                r = a << sh;
                c = (sh == 0) ? 1'b0 : a[16 - sh];
            end
            4'h7: begin
                r = a >> sh;
                c = (sh == 0) ? 1'b0 : a[sh - 1];
            end
            4'h8: begin
                r = 16'($signed(a) >>> sh);
                c = (sh == 0) ? 1'b0 : a[sh - 1];
            end
            4'hA: r = b;
            4'hE: r = a;
            4'hB, 4'hC, 4'hD: begin
                if (!MD) begin
                    r = 16'h0000; v = 1'b1; wb = 1'b0;
                end else if (op == 4'hB) begin
                    p = 32'(a) * 32'(b);
                    r = p[15:0];
                    c = (p[31:16] != 16'h0);
                    v = c;
                end else if (b == 16'h0) begin
                    r = (op == 4'hC) ? 16'hFFFF : a;
                    v = 1'b1;
                end else begin
                    r = (op == 4'hC) ? a / b : a % b;
                end
            end
            default: r = '0;
        endcase
        return {wb, r[15], r == 16'h0, c, v, r};
    endfunction

    task automatic do_op(input string tag, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [20:0] exp);
        int lat;
        int exp_lat;
        exp_lat = (MD && (op == 4'hB || op == 4'hC || op == 4'hD)) ? 16 : 1;
        @(negedge clk);
        valid_in = 1'b1; aluOp_in = op; srcA_in = a; srcB_in = b;
        @(posedge clk); #1;
        valid_in = 1'b0;
        lat = 1;
        if (op == 4'hF) begin
            chk({tag, "_nop_valid"}, 32'(valid_out), 0);
            chk({tag, "_nop_hold"}, 32'(result_out), 32'(last_res));
        end else begin
            while (!valid_out && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            chk({tag, "_lat"}, lat, exp_lat);
            chk({tag, "_res"}, 32'(result_out), 32'(exp[15:0]));
            chk({tag, "_flags"}, 32'(flags_out), 32'(exp[19:16]));
            chk({tag, "_wb"}, 32'(wb_en_out), 32'(exp[20]));
            last_res = exp[15:0];
        end
    endtask

    initial begin
        int low;
        int pulses;
        logic [3:0]  rop;
        logic [15:0] ra, rb;

        reset = 1'b1; flush = 1'b0; valid_in = 1'b0;
        aluOp_in = '0; srcA_in = '0; srcB_in = '0;
        last_res = '0;

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_ready", 32'(ready_out), 1);
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_res", 32'(result_out), 0);
        chk("rst_flags", 32'(flags_out), 0);
        chk("rst_wb", 32'(wb_en_out), 0);

        do_op("add_ovf", 4'h0, 16'h7FFF, 16'h0001, {1'b1, 4'b1001, 16'h8000});
        @(posedge clk); #1;
        chk("pulse_end", 32'(valid_out), 0);
        chk("pulse_hold", 32'(result_out), 32'h8000);

        do_op("cmp_eq", 4'h9, 16'h0005, 16'h0005, {1'b0, 4'b0110, 16'h0000});
        do_op("sra", 4'h8, 16'h8004, 16'h0002, {1'b1, 4'b1000, 16'hE001});
        do_op("sll", 4'h6, 16'h8001, 16'h0001, {1'b1, 4'b0010, 16'h0002});
        do_op("srl0", 4'h7, 16'h8001, 16'h0000, {1'b1, 4'b1000, 16'h8001});

        @(negedge clk);
        flush = 1'b1; valid_in = 1'b1; aluOp_in = 4'h0;
        srcA_in = 16'h0001; srcB_in = 16'h0001;
        @(posedge clk); #1;
        flush = 1'b0; valid_in = 1'b0;
        chk("idle_flush_valid", 32'(valid_out), 0);
        chk("idle_flush_hold", 32'(result_out), 32'(last_res));

        if (MD) begin
            @(negedge clk);
            valid_in = 1'b1; aluOp_in = 4'hB;
            srcA_in = 16'h0100; srcB_in = 16'h0100;
            @(posedge clk); #1;
            aluOp_in = 4'h0; srcA_in = 16'h1111; srcB_in = 16'h2222;
            low = 0; pulses = 0;
            for (int k = 0; k < 16; k++) begin
                if (!ready_out) low++;
                if (valid_out) pulses++;
                @(posedge clk); #1;
            end
            chk("mul_ready_low", low, 16);
            chk("mul_early_pulse", pulses, 0);
            chk("mul_valid", 32'(valid_out), 1);
            chk("mul_res", 32'(result_out), 0);
            chk("mul_flags", 32'(flags_out), 32'b0111);
            chk("mul_ready_back", 32'(ready_out), 1);
            @(posedge clk); #1;
            valid_in = 1'b0;
            chk("held_add_valid", 32'(valid_out), 1);
            chk("held_add_res", 32'(result_out), 32'h3333);
            last_res = 16'h3333;
            @(posedge clk); #1;
            chk("held_add_once", 32'(valid_out), 0);

            do_op("div", 4'hC, 16'h0064, 16'h0007, {1'b1, 4'b0000, 16'h000E});
            do_op("mod", 4'hD, 16'h0064, 16'h0007, {1'b1, 4'b0000, 16'h0002});
            do_op("div0", 4'hC, 16'h1234, 16'h0000, {1'b1, 4'b1001, 16'hFFFF});

            @(negedge clk);
            valid_in = 1'b1; aluOp_in = 4'hC;
            srcA_in = 16'h0064; srcB_in = 16'h0007;
            @(posedge clk); #1;
            valid_in = 1'b0;
            repeat (4) @(posedge clk);
            @(negedge clk);
            flush = 1'b1; valid_in = 1'b1; aluOp_in = 4'h0;
            srcA_in = 16'h0001; srcB_in = 16'h0001;
            @(posedge clk); #1;
            flush = 1'b0; valid_in = 1'b0;
            chk("busy_flush_valid", 32'(valid_out), 0);
            chk("busy_flush_ready", 32'(ready_out), 1);
            chk("busy_flush_hold", 32'(result_out), 32'(last_res));
            pulses = 0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                if (valid_out) pulses++;
            end
            chk("busy_flush_quiet", pulses, 0);

            @(negedge clk);
            valid_in = 1'b1; aluOp_in = 4'hB;
            srcA_in = 16'h00FF; srcB_in = 16'h0003;
            @(posedge clk); #1;
            valid_in = 1'b0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            chk("busy_rst_ready", 32'(ready_out), 1);
            chk("busy_rst_res", 32'(result_out), 0);
            chk("busy_rst_flags", 32'(flags_out), 0);
            last_res = 16'h0000;
            pulses = 0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                if (valid_out) pulses++;
            end
            chk("busy_rst_quiet", pulses, 0);
        end else begin
            do_op("mul_off", 4'hB, 16'h0100, 16'h0100, {1'b0, 4'b0101, 16'h0000});
            do_op("div_off", 4'hC, 16'h0064, 16'h0007, {1'b0, 4'b0101, 16'h0000});
            chk("off_ready", 32'(ready_out), 1);
        end

        do_op("nop", 4'hF, 16'hAAAA, 16'h5555, 21'h0);

        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = 16'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            do_op($sformatf("rnd%0d_op%0h", i, rop), rop, ra, rb,
                  model(rop, ra, rb));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
